reg_file_wb: RTL
================

# reg_file_wb

Register file and writeback stage for the basic processor datapath. It sits on both sides of the ALU:
- its two combinational read ports drive ALU InputA/InputB;
- its write port commits the ALU's Out on the next rising clock edge.

It also holds the processor status flags (Zero, Parity, test bit) captured from the ALU. The test bit feeds back as the ALU's SC_in.

## Interface
Parameters:
- W, 8, data width of each register (matches ALU W)
- A, 3, address width; 2**A registers

Ports:
- Clk  input  1  system clock; all state updates on rising edge
- Reset  input  1  synchronous, active-low reset; sampled on rising edge of Clk
- RdAddrA  input  A  read address, port A
- RdAddrB  input  A  read address, port B
- DataOutA  output  W  contents of register RdAddrA (to ALU InputA)
- DataOutB  output  W  contents of register RdAddrB (to ALU InputB)
- WrEn  input  1  commit WrData to register WrAddr at next edge
- WrAddr  input  A  write address
- WrData  input  W  write data (ALU Out)
- FlagEn  input  1  capture ZeroIn and ParityIn at next edge
- BitEn  input  1  capture BitIn at next edge
- ZeroIn  input  1  ALU Zero
- ParityIn  input  1  ALU Parity
- BitIn  input  1  ALU OutBit (may be x when BitEn=0)
- ZeroFlag  output  1  registered zero flag
- ParityFlag  output  1  registered parity flag
- BitFlag  output  1  registered test/carry bit (to ALU SC_in)

## Operation
- Storage: 2**A registers of W bits. No register is hardwired; all are writable.
- Reads: DataOutA/DataOutB are combinational functions of the read address and stored state. There is no read latency.
- Write: on a rising edge with Reset=1 and WrEn=1, reg[WrAddr] <= WrData. All other registers hold.
- Flags: on a rising edge with Reset=1:
  - FlagEn=1 loads ZeroFlag <= ZeroIn and ParityFlag <= ParityIn;
  - BitEn=1 loads BitFlag <= BitIn;
  - the two enables are independent; with an enable low, its flags hold.
- BitIn is never sampled while BitEn=0, so an x on OutBit must not corrupt BitFlag.
- Reset: on a rising edge with Reset=0:
  - all registers and all three flags become 0;
  - Reset dominates WrEn, FlagEn and BitEn in the same cycle.
- Reset values of outputs:
  - DataOutA = DataOutB = 0 for any address;
  - ZeroFlag = ParityFlag = BitFlag = 0.
- Before the first reset, contents are undefined. The bench must apply reset first.

## Timing
- Write-to-read latency: 1 cycle. Data written at edge N is visible on DataOutA/B after edge N.
- Same-cycle read of WrAddr while WrEn=1: behaviour set by the configuration macro below.
- Simultaneous read of the same address on both ports is legal; both outputs are identical.
- Back-to-back writes to the same address: the last edge wins. There is no write combining.
- Flag capture latency: 1 cycle. The ALU status in cycle N appears on the flag outputs after edge N.
- No handshake and no stall. The block accepts one write and one flag update every cycle.

## Configuration
- Macro: REG_FILE_FORWARD_EN.
- Defined:
  - if WrEn=1 and RdAddrX == WrAddr, DataOutX = WrData combinationally (write-through bypass);
  - likewise BitFlag output = BitIn when BitEn=1 (same-cycle carry forward);
  - stored-state update is unchanged.
- Undefined:
  - reads always return the pre-edge stored value;
  - a same-cycle read of the register being written returns old data.

## Structure
- Definitions package: add constants REG_W=8 and REG_ADDR_W=3 so the ALU, decoder and this block share widths.
- Sub-module flag_reg: holds the three enable-gated flag flops and shares the same Clk/Reset. The array and read muxes stay in reg_file_wb.

## Test plan
- Reset=0 for 1 edge after writes to all registers → every DataOutA/B reads 0x00; all flags 0.
- WrEn=1, WrAddr=3, WrData=0xA5 at edge N; RdAddrA=3 → after edge N, DataOutA=0xA5; other registers unchanged.
- Same cycle: WrEn=1, WrAddr=5, WrData=0x3C, RdAddrB=5, old value 0x11 → DataOutB=0x3C with REG_FILE_FORWARD_EN, 0x11 without; 0x3C after edge either way.
- FlagEn=1, ZeroIn=1, ParityIn=1; BitEn=0, BitIn=x → after edge ZeroFlag=1, ParityFlag=1, BitFlag holds 0 (not x).
- WrEn=1, WrAddr=2, WrData=0xFF and Reset=0 in the same cycle → after edge reg[2]=0x00.
- Write 0x01 to reg 1 then 0x02 to reg 1 on consecutive edges, RdAddrA=RdAddrB=1 → both read 0x01 after the first edge and 0x02 after the second.

Source files
------------

// File: rtl/reg_file_wb_pkg.sv
// Shared datapath widths and the status-flag bundle for the register file / writeback stage.
// Constants are shared by the ALU, decoder and reg_file_wb so widths stay consistent.
package reg_file_wb_pkg;
  localparam int REG_W      = 8;
  localparam int REG_ADDR_W = 3;

  typedef struct packed {
    logic zero;
    logic parity;
    logic test;
  } flags_t;
endpackage

// File: rtl/flag_reg.sv
// Processor status flags (Zero, Parity, test bit), each group loaded by its own enable.
// Latency: one edge from ZeroIn/ParityIn/BitIn to flag outputs; no stall, one update per cycle.
module flag_reg
  import reg_file_wb_pkg::*;
(
  input  logic Clk,
  input  logic Reset,
  input  logic FlagEn,
  input  logic BitEn,
  input  logic ZeroIn,
  input  logic ParityIn,
  input  logic BitIn,
  output logic ZeroFlag,
  output logic ParityFlag,
  output logic BitFlag
);

  flags_t flags_q;

  // BitIn is only looked at under BitEn, so an unknown OutBit never reaches the flop.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      flags_q <= '0;
    end else begin
      if (FlagEn) begin
        flags_q.zero   <= ZeroIn;
        flags_q.parity <= ParityIn;
      end
      if (BitEn) begin
        flags_q.test <= BitIn;
      end
    end
  end

  assign ZeroFlag   = flags_q.zero;
  assign ParityFlag = flags_q.parity;
  assign BitFlag    = flags_q.test;

endmodule

// File: rtl/reg_file_wb.sv
// Register file + writeback: two combinational read ports, one write port, status flags.
// Write/flag latency one edge; no handshake. REG_FILE_FORWARD_EN adds same-cycle write-through.
module reg_file_wb
  import reg_file_wb_pkg::*;
#(
  parameter int W = REG_W,
  parameter int A = REG_ADDR_W
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [A-1:0] RdAddrA,
  input  logic [A-1:0] RdAddrB,
  output logic [W-1:0] DataOutA,
  output logic [W-1:0] DataOutB,
  input  logic         WrEn,
  input  logic [A-1:0] WrAddr,
  input  logic [W-1:0] WrData,
  input  logic         FlagEn,
  input  logic         BitEn,
  input  logic         ZeroIn,
  input  logic         ParityIn,
  input  logic         BitIn,
  output logic         ZeroFlag,
  output logic         ParityFlag,
  output logic         BitFlag
);

  localparam int DEPTH = 1 << A;

  logic [W-1:0] regs [DEPTH];
  logic         bit_q;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (WrEn) begin
      regs[WrAddr] <= WrData;
    end
  end

  flag_reg u_flag_reg (
    .Clk        (Clk),
    .Reset      (Reset),
    .FlagEn     (FlagEn),
    .BitEn      (BitEn),
    .ZeroIn     (ZeroIn),
    .ParityIn   (ParityIn),
    .BitIn      (BitIn),
    .ZeroFlag   (ZeroFlag),
    .ParityFlag (ParityFlag),
    .BitFlag    (bit_q)
  );

`ifdef REG_FILE_FORWARD_EN
  // Write-through: a read of the register being written sees the incoming ALU result.
  assign DataOutA = (WrEn && (RdAddrA == WrAddr)) ? WrData : regs[RdAddrA];
  assign DataOutB = (WrEn && (RdAddrB == WrAddr)) ? WrData : regs[RdAddrB];
  assign BitFlag  = BitEn ? BitIn : bit_q;
`else
  assign DataOutA = regs[RdAddrA];
  assign DataOutB = regs[RdAddrB];
  assign BitFlag  = bit_q;
`endif

endmodule
